// File: rtl/cal_pkg.sv
// Shared types and constants for the calculator divider.
// The FSM walks IDLE -> RUN -> DONE, and DONE commits the results.
package cal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    // Wide enough for any practical DW. Users slice off the low DW bits.
    localparam logic [63:0] DZ_QUOT = '1;

endpackage

// File: rtl/cal_div_step.sv
// One combinational restoring-division step.
// Shift in one dividend bit and subtract the divisor when it fits.
module cal_div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   i_p,
    input  logic          i_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW:0]   o_p,
    output logic          o_qbit
);

    logic [VW:0] w_t;
    logic [VW:0] w_d;

    assign w_t = {i_p[VW-1:0], i_bit};
    assign w_d = {1'b0, i_divisor};

    // A set top bit in P would make the true T exceed any VW-bit divisor.
    assign o_qbit = i_p[VW] | (w_t >= w_d);
    assign o_p    = o_qbit ? (w_t - w_d) : w_t;

endmodule

// File: rtl/cal_div.sv
// Sequential unsigned restoring divider. It produces one quotient bit per clock
// and uses a start/done handshake.
module cal_div
    import cal_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_quotient,
    output logic [VW-1:0] o_remainder,
    output logic          o_div_zero
);

    localparam int CW = $clog2(DW);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_d;
    logic [VW:0]   r_p;
    logic [CW-1:0] r_cnt;
    logic          r_dz;
    logic [VW:0]   w_p_nxt;
    logic          w_qbit;

    cal_div_step #(.VW(VW)) u_step (
        .i_p       (r_p),
        .i_bit     (r_a[DW-1]),
        .i_divisor (r_d),
        .o_p       (w_p_nxt),
        .o_qbit    (w_qbit)
    );

    // RUN performs DW-1 steps. DONE performs the last step and commits it, so
    // the results appear DW edges after acceptance.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (i_start) w_state_nxt = (i_divisor == '0) ? DONE : RUN;
            RUN:  if (r_cnt == CW'(DW-2)) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    assign o_busy = (r_state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_dz        <= 1'b0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else begin
            o_done <= (r_state == DONE);
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a   <= i_dividend;
                        r_d   <= i_divisor;
                        r_p   <= '0;
                        r_q   <= '0;
                        r_cnt <= '0;
                        r_dz  <= (i_divisor == '0);
                    end
                end
                RUN: begin
                    r_p   <= w_p_nxt;
                    r_q   <= {r_q[DW-2:0], w_qbit};
                    r_a   <= {r_a[DW-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_cnt <= '0;
                    if (r_dz) begin
                        o_quotient  <= DZ_QUOT[DW-1:0];
                        o_remainder <= '0;
                        o_div_zero  <= 1'b1;
                    end else begin
                        o_quotient  <= {r_q[DW-2:0], w_qbit};
                        o_remainder <= w_p_nxt[VW-1:0];
                        o_div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cal_div.sv
// Self-checking bench for cal_div. Results are compared with plain integer
// division and modulo.
module tb_cal_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_chk  = 0;
    int n_fail = 0;

    cal_div dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference model.
    task automatic ref_div(input int a, input int b, output int q, output int r,
                           output int dz, output int lat);
        if (b == 0) begin
            q = 255; r = 0; dz = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; dz = 0; lat = 8;
        end
    endtask

    // Runs one division and reports the latency in edges after acceptance
    // (-1 on timeout), the outputs in the done cycle, and whether done is still
    // high one cycle later.
    task automatic run_div(input int a, input int b, output int lat, output int q,
                           output int r, output int dz, output int b0,
                           output int bd, output int wide);
        @(negedge clk);
        start = 1'b1; dividend = 8'(a); divisor = 4'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
        b0 = int'(busy);
        lat = -1; q = -1; r = -1; dz = -1; bd = -1; wide = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k; q = int'(quotient); r = int'(remainder);
                dz = int'(div_zero); bd = int'(busy);
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        wide = int'(done);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, quotient, remainder, div_zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int ta[5] = '{200, 255, 0, 9, 100};
        int tb[5] = '{7, 15, 5, 10, 3};
        int lat, q, r, dz, b0, bd, wide, eq, er, edz, elat;
        for (int i = 0; i < 5; i++) begin
            run_div(ta[i], tb[i], lat, q, r, dz, b0, bd, wide);
            ref_div(ta[i], tb[i], eq, er, edz, elat);
            n_chk++;
            if (lat !== elat || q !== eq || r !== er || dz !== edz) begin
                n_fail++;
                $display("FAIL basic_%0d_%0d got lat=%0d q=%0d r=%0d dz=%0d want lat=%0d q=%0d r=%0d dz=%0d",
                         ta[i], tb[i], lat, q, r, dz, elat, eq, er, edz);
            end
            n_chk++;
            if (b0 !== 1 || bd !== 0 || wide !== 0) begin
                n_fail++;
                $display("FAIL handshake_%0d_%0d got busy0=%0d busy_done=%0d done_next=%0d want 1 0 0",
                         ta[i], tb[i], b0, bd, wide);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, q, r, dz, b0, bd, wide;
        run_div(100, 0, lat, q, r, dz, b0, bd, wide);
        n_chk++;
        if (lat !== 1 || q !== 255 || r !== 0 || dz !== 1 || b0 !== 1 || bd !== 0 || wide !== 0) begin
            n_fail++;
            $display("FAIL div_zero got lat=%0d q=%0d r=%0d dz=%0d b0=%0d bd=%0d w=%0d want 1 255 0 1 1 0 0",
                     lat, q, r, dz, b0, bd, wide);
        end
        run_div(100, 3, lat, q, r, dz, b0, bd, wide);
        n_chk++;
        if (lat !== 8 || q !== 33 || r !== 1 || dz !== 0) begin
            n_fail++;
            $display("FAIL div_zero_clear got lat=%0d q=%0d r=%0d dz=%0d want 8 33 1 0",
                     lat, q, r, dz);
        end
    endtask

    task automatic test_ignore_start;
        int lat = -1;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                start = 1'b1; dividend = 8'd50; divisor = 4'd5;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat = k; break; end
        end
        n_chk++;
        if (lat !== 8 || quotient !== 8'd28 || remainder !== 4'd4 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want 8 28 4", lat, quotient, remainder);
        end
        repeat (6) @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
            n_fail++;
            $display("FAIL hold got done=%0b busy=%0b q=%0d r=%0d want 0 0 28 4",
                     done, busy, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat = -1;
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 4'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) break;
        end
        start = 1'b1; dividend = 8'd250; divisor = 4'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept got busy=%0b want 1", busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        n_chk++;
        if (lat !== 8 || quotient !== 8'd27 || remainder !== 4'd7) begin
            n_fail++;
            $display("FAIL b2b_result got lat=%0d q=%0d r=%0d want 8 27 7", lat, quotient, remainder);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, q, r, dz, b0, bd, wide;
        int seen = 0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd255; divisor = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, quotient, remainder, div_zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done got %0d active cycles want 0", seen);
        end
        run_div(255, 2, lat, q, r, dz, b0, bd, wide);
        n_chk++;
        if (lat !== 8 || q !== 127 || r !== 1 || dz !== 0) begin
            n_fail++;
            $display("FAIL reset_rerun got lat=%0d q=%0d r=%0d want 8 127 1", lat, q, r);
        end
    endtask

    task automatic test_sweep;
        int lat, q, r, dz, b0, bd, wide, eq, er, edz, elat, a, b;
        int stride = int'($urandom_range(2047, 0)) * 2 + 1;
        int off    = int'($urandom_range(4095, 0));
        for (int i = 0; i < 4096; i++) begin
            int idx = (i * stride + off) % 4096;
            a = idx / 16; b = idx % 16;
            run_div(a, b, lat, q, r, dz, b0, bd, wide);
            ref_div(a, b, eq, er, edz, elat);
            n_chk++;
            if (lat !== elat || q !== eq || r !== er || dz !== edz || wide !== 0) begin
                n_fail++;
                $display("FAIL sweep_%0d_%0d got lat=%0d q=%0d r=%0d dz=%0d w=%0d want %0d %0d %0d %0d 0",
                         a, b, lat, q, r, dz, wide, elat, eq, er, edz);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
